vpu_cmd_sequencer: RTL and testbench

Parametrised command queue and issue sequencer between the CPU command port and `matrix_unit`. It buffers up to DEPTH geometry commands (create, delete, translate, rotate, scale, and the rest). It issues them one at a time over the `go`/`busy` handshake and drops `create` commands while object memory is full. When the queue drains after work has been done, it requests a clipper refresh, so the host no longer hand-sequences each operation.

---
 rtl/vpu_cmd_sequencer.sv | 161 ++++++++++++++++
 tb/tb_vpu_cmd_sequencer.sv | 556 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_cmd_sequencer.sv
// Command FIFO and single-issue sequencer feeding matrix_unit over go/busy.
// Drops creates while object memory is full; requests a clipper refresh once the queue drains.
module vpu_cmd_sequencer #(
   parameter int DEPTH      = 8,
   parameter int VW         = 16,
   parameter int NV         = 8,
   parameter int OBJ_W      = 5,
   parameter int BUSY_TO    = 4,
   parameter int REFRESH_EN = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [3:0]              cmd_op,
   input  logic [3:0]              cmd_code,
   input  logic [OBJ_W-1:0]        cmd_obj_num,
   input  logic [1:0]              cmd_obj_type,
   input  logic [7:0]              cmd_obj_color,
   input  logic [NV*VW-1:0]        cmd_v,
   input  logic                    flush,
   output logic                    go,
   input  logic                    busy,
   input  logic                    obj_mem_full,
   output logic [3:0]              gmt_op,
   output logic [3:0]              gmt_code,
   output logic [OBJ_W-1:0]        obj_num,
   output logic [1:0]              obj_type,
   output logic [7:0]              obj_color,
   output logic [NV*VW-1:0]        v,
   output logic                    err_drop,
   output logic                    refresh_req,
   output logic [$clog2(DEPTH):0]  level
);

   localparam int PW    = $clog2(DEPTH);
   localparam int LW    = PW + 1;
   localparam int VBITS = NV * VW;
   localparam int EW    = 18 + OBJ_W + VBITS;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   logic [EW-1:0]    mem [DEPTH];
   logic [PW-1:0]    wr_ptr_reg;
   logic [PW-1:0]    rd_ptr_reg;
   logic [LW-1:0]    level_reg;
   logic [1:0]       state_reg;
   logic [3:0]       to_cnt_reg;
   logic             dirty_reg;

   logic             push;
   logic             pop;
   logic             drop_head;
   logic [3:0]       head_op;
   logic [3:0]       head_code;
   logic [OBJ_W-1:0] head_obj;
   logic [1:0]       head_type;
   logic [7:0]       head_color;
   logic [VBITS-1:0] head_v;

   assign cmd_ready = (level_reg < LW'(DEPTH));
   assign level     = level_reg;

   // A push coinciding with flush is discarded; flush also blocks the IDLE pop.
   assign push = cmd_valid && cmd_ready && !flush;
   assign pop  = (state_reg == S_IDLE) && (level_reg != '0) && !flush;

   assign {head_op, head_code, head_obj, head_type, head_color, head_v} = mem[rd_ptr_reg];
   assign drop_head = (head_op == 4'd0) && obj_mem_full;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_reg] <= {cmd_op, cmd_code, cmd_obj_num, cmd_obj_type, cmd_obj_color, cmd_v};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else if (flush) begin
         rd_ptr_reg <= wr_ptr_reg;
         level_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         level_reg <= level_reg + LW'(push) - LW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= S_IDLE;
         to_cnt_reg  <= '0;
         dirty_reg   <= 1'b0;
         go          <= 1'b0;
         err_drop    <= 1'b0;
         refresh_req <= 1'b0;
         gmt_op      <= '0;
         gmt_code    <= '0;
         obj_num     <= '0;
         obj_type    <= '0;
         obj_color   <= '0;
         v           <= '0;
      end else begin
         go          <= 1'b0;
         err_drop    <= 1'b0;
         refresh_req <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (pop) begin
                  if (drop_head) begin
                     err_drop <= 1'b1;
                  end else begin
                     gmt_op     <= head_op;
                     gmt_code   <= head_code;
                     obj_num    <= head_obj;
                     obj_type   <= head_type;
                     obj_color  <= head_color;
                     v          <= head_v;
                     go         <= 1'b1;
                     dirty_reg  <= 1'b1;
                     to_cnt_reg <= '0;
                     state_reg  <= S_ARM;
                  end
               end else if ((level_reg == '0) && dirty_reg && (REFRESH_EN != 0)) begin
                  refresh_req <= 1'b1;
                  dirty_reg   <= 1'b0;
               end
            end
            S_ARM: begin
               // A unit that never raises busy is treated as having finished.
               if (busy) begin
                  state_reg <= S_WAIT;
               end else if (to_cnt_reg == 4'(BUSY_TO - 1)) begin
                  state_reg <= S_GAP;
               end else begin
                  to_cnt_reg <= to_cnt_reg + 4'd1;
               end
            end
            S_WAIT: begin
               if (!busy) begin
                  state_reg <= S_GAP;
               end
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vpu_cmd_sequencer.sv
// Self-checking bench for vpu_cmd_sequencer: a queue-based reference model plus a
// behavioural matrix_unit that raises busy for busy_len cycles, one cycle after each go.
module tb_vpu_cmd_sequencer;

   localparam int BUSY_TO = 4;

   typedef struct packed {
      logic [3:0]   op;
      logic [3:0]   code;
      logic [4:0]   obj;
      logic [1:0]   typ;
      logic [7:0]   color;
      logic [127:0] v;
   } cmd_t;

   typedef struct {
      int   cyc;
      cmd_t c;
   } ev_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         cmd_valid = 1'b0;
   logic         cmd_ready;
   logic [3:0]   cmd_op = '0;
   logic [3:0]   cmd_code = '0;
   logic [4:0]   cmd_obj_num = '0;
   logic [1:0]   cmd_obj_type = '0;
   logic [7:0]   cmd_obj_color = '0;
   logic [127:0] cmd_v = '0;
   logic         flush = 1'b0;
   logic         go;
   logic         busy;
   logic         obj_mem_full = 1'b0;
   logic [3:0]   gmt_op;
   logic [3:0]   gmt_code;
   logic [4:0]   obj_num;
   logic [1:0]   obj_type;
   logic [7:0]   obj_color;
   logic [127:0] v;
   logic         err_drop;
   logic         refresh_req;
   logic [3:0]   level;

   logic mu_busy = 1'b0;
   logic hold_busy = 1'b0;
   int   busy_len = 3;
   int   mu_cnt = 0;
   bit   mu_pend = 0;

   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   acc_count = 0;
   int   acc_cyc[$];
   ev_t  go_log[$];
   int   drop_log[$];
   int   ref_log[$];
   cmd_t cur;

   assign busy = mu_busy | hold_busy;
   assign cur  = {gmt_op, gmt_code, obj_num, obj_type, obj_color, v};

   vpu_cmd_sequencer dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_code(cmd_code), .cmd_obj_num(cmd_obj_num),
      .cmd_obj_type(cmd_obj_type), .cmd_obj_color(cmd_obj_color), .cmd_v(cmd_v),
      .flush(flush), .go(go), .busy(busy), .obj_mem_full(obj_mem_full),
      .gmt_op(gmt_op), .gmt_code(gmt_code), .obj_num(obj_num), .obj_type(obj_type),
      .obj_color(obj_color), .v(v), .err_drop(err_drop), .refresh_req(refresh_req),
      .level(level)
   );

   initial forever #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // matrix_unit model
   initial forever begin
      @(posedge clk);
      #1;
      if (rst) begin
         mu_busy = 1'b0;
         mu_cnt  = 0;
         mu_pend = 0;
      end else begin
         if (mu_cnt > 0) begin
            mu_cnt--;
            if (mu_cnt == 0) mu_busy = 1'b0;
         end else if (mu_pend) begin
            mu_pend = 0;
            if (busy_len > 0) begin
               mu_busy = 1'b1;
               mu_cnt  = busy_len;
            end
         end
         if (go) mu_pend = 1;
      end
   end

   // Event monitor: logs every go / err_drop / refresh_req and checks field stability.
   initial begin
      cmd_t prev;
      prev = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst) begin
            checks++;
            if (!go && cur !== prev) begin
               failures++;
               $display("FAIL field_stability cyc=%0d got=%h held=%h", cyc, cur, prev);
            end
            if (go) begin
               go_log.push_back('{cyc: cyc, c: cur});
               $display("go cyc=%0d op=%0d code=%0h obj=%0d type=%0d color=%0h v0=%0d",
                        cyc, gmt_op, gmt_code, obj_num, obj_type, obj_color, v[15:0]);
            end
            if (err_drop) begin
               drop_log.push_back(cyc);
               $display("err_drop cyc=%0d", cyc);
            end
            if (refresh_req) begin
               ref_log.push_back(cyc);
               $display("refresh_req cyc=%0d", cyc);
            end
         end
         prev = cur;
      end
   end

   function automatic cmd_t rand_cmd();
      cmd_t c;
      logic [3:0] ops [7] = '{4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
      c.op    = ops[$urandom_range(0, 6)];
      c.code  = 4'($urandom);
      c.obj   = 5'($urandom);
      c.typ   = 2'($urandom);
      c.color = 8'($urandom);
      c.v     = {$urandom(), $urandom(), $urandom(), $urandom()};
      return c;
   endfunction

   task automatic clear_logs();
      go_log.delete();
      drop_log.delete();
      ref_log.delete();
      acc_cyc.delete();
      acc_count = 0;
   endtask

   task automatic push_cmd(input cmd_t c);
      bit ok = 0;
      {cmd_op, cmd_code, cmd_obj_num, cmd_obj_type, cmd_obj_color, cmd_v} = c;
      cmd_valid = 1'b1;
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         if (cmd_ready) begin
            @(posedge clk);
            #1;
            ok = 1;
         end
      end
      cmd_valid = 1'b0;
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL push_timeout got=not_accepted exp=accepted op=%0d", c.op);
      end else begin
         acc_count++;
         acc_cyc.push_back(cyc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (go !== 1'b0 || err_drop !== 1'b0 || refresh_req !== 1'b0) begin
         failures++;
         $display("FAIL reset_pulses got=%b%b%b exp=000", go, err_drop, refresh_req);
      end
      checks++;
      if (level !== 4'd0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_level got=%0d/%b exp=0/1", level, cmd_ready);
      end
      checks++;
      if (cur !== '0) begin
         failures++;
         $display("FAIL reset_fields got=%h exp=0", cur);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
      // Reset in the middle of a command that is still busy, with 3 more queued.
      busy_len = 20;
      clear_logs();
      for (int i = 0; i < 4; i++) push_cmd(rand_cmd());
      checks++;
      if (level !== 4'd3) begin
         failures++;
         $display("FAIL reset_prefill_level got=%0d exp=3", level);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (go !== 1'b0 || level !== 4'd0 || cmd_ready !== 1'b1 || refresh_req !== 1'b0) begin
         failures++;
         $display("FAIL reset_midwait got=go%b lvl%0d rdy%b ref%b exp=go0 lvl0 rdy1 ref0",
                  go, level, cmd_ready, refresh_req);
      end
      checks++;
      if (cur !== '0) begin
         failures++;
         $display("FAIL reset_midwait_fields got=%h exp=0", cur);
      end
      clear_logs();
      repeat (15) @(posedge clk);
      #1;
      checks++;
      if (go_log.size() != 0 || ref_log.size() != 0) begin
         failures++;
         $display("FAIL reset_quiet got=go%0d ref%0d exp=go0 ref0", go_log.size(), ref_log.size());
      end
   endtask

   task automatic test_order();
      cmd_t exp [4];
      busy_len = 3;
      obj_mem_full = 1'b0;
      clear_logs();
      for (int i = 0; i < 4; i++) exp[i] = rand_cmd();
      exp[0].op = 4'd0; exp[0].typ = 2'd3;
      exp[1].op = 4'd0; exp[1].typ = 2'd2;
      exp[2].op = 4'd0; exp[2].typ = 2'd1;
      exp[3].op = 4'd7; exp[3].obj = 5'd0; exp[3].code = 4'hA;
      for (int i = 0; i < 4; i++) push_cmd(exp[i]);
      repeat (60) @(posedge clk);
      #1;
      checks++;
      if (go_log.size() != 4) begin
         failures++;
         $display("FAIL order_go_count got=%0d exp=4", go_log.size());
      end
      for (int i = 0; i < 4; i++) begin
         if (i < go_log.size()) begin
            checks++;
            if (go_log[i].c !== exp[i]) begin
               failures++;
               $display("FAIL order_fields[%0d] got=%h exp=%h", i, go_log[i].c, exp[i]);
            end
            if (i > 0) begin
               checks++;
               if (go_log[i].cyc - go_log[i-1].cyc != 7) begin
                  failures++;
                  $display("FAIL order_spacing[%0d] got=%0d exp=7", i, go_log[i].cyc - go_log[i-1].cyc);
               end
            end
         end
      end
      if (go_log.size() > 0 && acc_cyc.size() > 0) begin
         checks++;
         if (go_log[0].cyc != acc_cyc[0] + 2) begin
            failures++;
            $display("FAIL order_latency got=%0d exp=%0d", go_log[0].cyc, acc_cyc[0] + 2);
         end
      end
      checks++;
      if (ref_log.size() != 1 || drop_log.size() != 0) begin
         failures++;
         $display("FAIL order_refresh_count got=ref%0d drop%0d exp=ref1 drop0", ref_log.size(), drop_log.size());
      end else if (go_log.size() == 4) begin
         checks++;
         if (ref_log[0] != go_log[3].cyc + 7) begin
            failures++;
            $display("FAIL order_refresh_time got=%0d exp=%0d", ref_log[0], go_log[3].cyc + 7);
         end
      end
   endtask

   task automatic test_backpressure();
      cmd_t exp [10];
      busy_len = 2;
      obj_mem_full = 1'b0;
      hold_busy = 1'b1;
      clear_logs();
      for (int i = 0; i < 10; i++) exp[i] = rand_cmd();
      fork
         begin
            for (int i = 0; i < 10; i++) push_cmd(exp[i]);
         end
         begin
            repeat (14) @(negedge clk);
            checks++;
            if (level !== 4'd8 || cmd_ready !== 1'b0) begin
               failures++;
               $display("FAIL full_level got=%0d/%b exp=8/0", level, cmd_ready);
            end
            checks++;
            if (acc_count != 9 || go_log.size() != 1) begin
               failures++;
               $display("FAIL full_held got=acc%0d go%0d exp=acc9 go1", acc_count, go_log.size());
            end
            hold_busy = 1'b0;
         end
      join
      repeat (120) @(posedge clk);
      #1;
      checks++;
      if (go_log.size() != 10 || acc_count != 10) begin
         failures++;
         $display("FAIL full_go_count got=go%0d acc%0d exp=10", go_log.size(), acc_count);
      end
      for (int i = 0; i < 10; i++) begin
         if (i < go_log.size()) begin
            checks++;
            if (go_log[i].c !== exp[i]) begin
               failures++;
               $display("FAIL full_fields[%0d] got=%h exp=%h", i, go_log[i].c, exp[i]);
            end
         end
      end
      checks++;
      if (ref_log.size() != 1) begin
         failures++;
         $display("FAIL full_refresh got=%0d exp=1", ref_log.size());
      end
   endtask

   task automatic test_create_drop();
      cmd_t c0;
      cmd_t c1;
      busy_len = 2;
      obj_mem_full = 1'b1;
      clear_logs();
      c0 = rand_cmd(); c0.op = 4'd0; c0.typ = 2'd2;
      c1 = rand_cmd(); c1.op = 4'd4; c1.obj = 5'd1; c1.code = 4'd2; c1.v[15:0] = 16'd300;
      push_cmd(c0);
      push_cmd(c1);
      repeat (30) @(posedge clk);
      #1;
      obj_mem_full = 1'b0;
      checks++;
      if (drop_log.size() != 1) begin
         failures++;
         $display("FAIL drop_count got=%0d exp=1", drop_log.size());
      end else if (acc_cyc.size() == 2) begin
         checks++;
         if (drop_log[0] != acc_cyc[0] + 2) begin
            failures++;
            $display("FAIL drop_time got=%0d exp=%0d", drop_log[0], acc_cyc[0] + 2);
         end
      end
      checks++;
      if (go_log.size() != 1) begin
         failures++;
         $display("FAIL drop_go_count got=%0d exp=1", go_log.size());
      end else begin
         checks++;
         if (go_log[0].c !== c1 || go_log[0].c.v[15:0] !== 16'd300) begin
            failures++;
            $display("FAIL drop_translate got=%h exp=%h", go_log[0].c, c1);
         end
      end
      checks++;
      if (ref_log.size() != 1) begin
         failures++;
         $display("FAIL drop_refresh got=%0d exp=1", ref_log.size());
      end
   endtask

   task automatic test_busy_timeout();
      cmd_t c0;
      cmd_t c1;
      busy_len = 0;
      clear_logs();
      c0 = rand_cmd(); c0.op = 4'd1; c0.obj = 5'd1;
      c1 = rand_cmd(); c1.op = 4'd0; c1.typ = 2'd2;
      push_cmd(c0);
      push_cmd(c1);
      repeat (30) @(posedge clk);
      #1;
      checks++;
      if (go_log.size() != 2) begin
         failures++;
         $display("FAIL timeout_go_count got=%0d exp=2", go_log.size());
      end else begin
         checks++;
         if (go_log[1].cyc - go_log[0].cyc != BUSY_TO + 2) begin
            failures++;
            $display("FAIL timeout_spacing got=%0d exp=%0d", go_log[1].cyc - go_log[0].cyc, BUSY_TO + 2);
         end
         checks++;
         if (go_log[0].c !== c0 || go_log[1].c !== c1) begin
            failures++;
            $display("FAIL timeout_fields got=%h,%h exp=%h,%h", go_log[0].c, go_log[1].c, c0, c1);
         end
      end
   endtask

   task automatic test_flush();
      cmd_t exp [6];
      cmd_t late;
      busy_len = 0;
      obj_mem_full = 1'b0;
      hold_busy = 1'b1;
      clear_logs();
      for (int i = 0; i < 6; i++) begin
         exp[i] = rand_cmd();
         push_cmd(exp[i]);
      end
      checks++;
      if (level !== 4'd5) begin
         failures++;
         $display("FAIL flush_prefill got=%0d exp=5", level);
      end
      {cmd_op, cmd_code, cmd_obj_num, cmd_obj_type, cmd_obj_color, cmd_v} = rand_cmd();
      cmd_valid = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      flush = 1'b0;
      checks++;
      if (level !== 4'd0 || cmd_ready !== 1'b1) begin
         failures++;
         $display("FAIL flush_level got=%0d/%b exp=0/1", level, cmd_ready);
      end
      repeat (5) @(posedge clk);
      #1;
      hold_busy = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (go_log.size() != 1 || ref_log.size() != 1 || level !== 4'd0) begin
         failures++;
         $display("FAIL flush_result got=go%0d ref%0d lvl%0d exp=go1 ref1 lvl0",
                  go_log.size(), ref_log.size(), level);
      end
      if (go_log.size() > 0) begin
         checks++;
         if (go_log[0].c !== exp[0]) begin
            failures++;
            $display("FAIL flush_inflight got=%h exp=%h", go_log[0].c, exp[0]);
         end
      end
      late = rand_cmd();
      push_cmd(late);
      repeat (20) @(posedge clk);
      #1;
      checks++;
      if (go_log.size() != 2 || ref_log.size() != 2) begin
         failures++;
         $display("FAIL flush_after got=go%0d ref%0d exp=go2 ref2", go_log.size(), ref_log.size());
      end else begin
         checks++;
         if (go_log[1].c !== late) begin
            failures++;
            $display("FAIL flush_after_fields got=%h exp=%h", go_log[1].c, late);
         end
      end
   endtask

   task automatic test_random();
      for (int r = 0; r < 3; r++) begin
         cmd_t cmds[$];
         cmd_t exp_go[$];
         int   gap_drops[$];
         int   n, n_drop, pend, base;
         busy_len = $urandom_range(0, 4);
         obj_mem_full = 1'($urandom_range(0, 1));
         n = $urandom_range(5, 12);
         n_drop = 0;
         pend = 0;
         clear_logs();
         // Creates are dropped while memory is full; every drop costs one IDLE cycle.
         for (int i = 0; i < n; i++) begin
            cmd_t c;
            c = rand_cmd();
            cmds.push_back(c);
            if (c.op == 4'd0 && obj_mem_full) begin
               n_drop++;
               pend++;
            end else begin
               exp_go.push_back(c);
               gap_drops.push_back(pend);
               pend = 0;
            end
         end
         base = (busy_len > 0) ? busy_len + 4 : BUSY_TO + 2;
         foreach (cmds[i]) push_cmd(cmds[i]);
         repeat (n * 10 + 30) @(posedge clk);
         #1;
         checks++;
         if (go_log.size() != exp_go.size() || drop_log.size() != n_drop) begin
            failures++;
            $display("FAIL rand%0d_counts got=go%0d drop%0d exp=go%0d drop%0d",
                     r, go_log.size(), drop_log.size(), exp_go.size(), n_drop);
         end
         for (int i = 0; i < exp_go.size(); i++) begin
            if (i < go_log.size()) begin
               checks++;
               if (go_log[i].c !== exp_go[i]) begin
                  failures++;
                  $display("FAIL rand%0d_fields[%0d] got=%h exp=%h", r, i, go_log[i].c, exp_go[i]);
               end
               if (i > 0) begin
                  checks++;
                  if (go_log[i].cyc - go_log[i-1].cyc != base + gap_drops[i]) begin
                     failures++;
                     $display("FAIL rand%0d_spacing[%0d] got=%0d exp=%0d", r, i,
                              go_log[i].cyc - go_log[i-1].cyc, base + gap_drops[i]);
                  end
               end
            end
         end
         checks++;
         if (ref_log.size() != ((exp_go.size() > 0) ? 1 : 0)) begin
            failures++;
            $display("FAIL rand%0d_refresh_count got=%0d exp=%0d", r, ref_log.size(),
                     (exp_go.size() > 0) ? 1 : 0);
         end else if (exp_go.size() > 0 && go_log.size() == exp_go.size()) begin
            checks++;
            if (ref_log[0] != go_log[go_log.size()-1].cyc + base + pend) begin
               failures++;
               $display("FAIL rand%0d_refresh_time got=%0d exp=%0d", r, ref_log[0],
                        go_log[go_log.size()-1].cyc + base + pend);
            end
         end
      end
      obj_mem_full = 1'b0;
   endtask

   initial begin
      test_reset();
      test_order();
      test_backpressure();
      test_create_drop();
      test_busy_timeout();
      test_flush();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
